// File: rtl/alu_mc.sv
// Multi-cycle RV32 integer ALU: single-cycle logic/shift/compare ops plus
// iterative shift-add MUL/MULHU, valid/ready on both sides, flush and illegal-op flag.
module alu_mc #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic              mul_hi;
  logic [XLEN-1:0]   result_q;
  logic              illegal_q;

  logic              accept;
  logic              is_mul;
  logic              op_illegal;
  logic [XLEN-1:0]   alu_res;
  logic [SHW-1:0]    shamt;

  assign ready_o   = (state == S_IDLE);
  assign valid_o   = (state == S_DONE);
  assign result_o  = result_q;
  assign illegal_o = illegal_q;
  assign accept    = valid_i && (state == S_IDLE) && !flush_i;
  assign shamt     = src2_i[SHW-1:0];
  assign is_mul    = (op_i == 4'd10) || (op_i == 4'd11);

  always_comb begin
    op_illegal = (op_i >= 4'd12) || (is_mul && !MUL_EN);
    alu_res    = '0;
    case (op_i)
      4'd0:    alu_res = src1_i + src2_i;
      4'd1:    alu_res = src1_i - src2_i;
      4'd2:    alu_res = src1_i & src2_i;
      4'd3:    alu_res = src1_i | src2_i;
      4'd4:    alu_res = src1_i ^ src2_i;
      4'd5:    alu_res = src1_i << shamt;
      4'd6:    alu_res = src1_i >> shamt;
      4'd7:    alu_res = $signed(src1_i) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
      default: alu_res = '0;
    endcase
  end

  // one shift-add step; the carry out of the upper half is shifted back in
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_step = (2*XLEN)'({sum, acc[XLEN-1:0]} >> 1);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (is_mul && !op_illegal) ? S_BUSY : S_DONE;
      S_BUSY:  if (cnt == CW'(1)) state_n = S_DONE;
      S_DONE:  if (ready_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush_i) state_n = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_hi    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (!flush_i) begin
      if (accept) begin
        if (is_mul && !op_illegal) begin
          cnt    <= CW'(XLEN);
          acc    <= '0;
          mcand  <= src1_i;
          mplier <= src2_i;
          mul_hi <= (op_i == 4'd11);
        end else begin
          result_q  <= op_illegal ? '0 : alu_res;
          illegal_q <= op_illegal;
        end
      end else if (state == S_BUSY) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_q  <= mul_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
          illegal_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a negedge
// monitor pops them on each output handshake; a MUL_EN=0 instance is checked directly.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in, ready_out, valid_out, ready_in, illegal;
  logic [3:0]  op;
  logic [31:0] src1, src2, result;

  logic        n_valid_in, n_ready_out, n_valid_out, n_illegal;
  logic [3:0]  n_op;
  logic [31:0] n_result;

  typedef struct {logic [31:0] r; logic ill;} exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32), .MUL_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
    .op_i(op), .src1_i(src1), .src2_i(src2), .valid_o(valid_out), .ready_i(ready_in),
    .result_o(result), .illegal_o(illegal)
  );

  alu_mc #(.XLEN(32), .MUL_EN(1'b0)) u_nomul (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .valid_i(n_valid_in), .ready_o(n_ready_out),
    .op_i(n_op), .src1_i(32'd3), .src2_i(32'd5), .valid_o(n_valid_out), .ready_i(1'b1),
    .result_o(n_result), .illegal_o(n_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // handshake happens at the next posedge; inputs only change at posedge+1
  always @(negedge clk) begin
    if (!rst && !flush && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ei, input bit push);
    int n = 0;
    while (!ready_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got ready_o=0 expected 1");
    end
    op = o; src1 = a; src2 = b; valid_in = 1'b1;
    if (push) sb.push_back('{er, ei});
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    logic [31:0] held;
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    op = '0; src1 = '0; src2 = '0; n_valid_in = 1'b0; n_op = '0;
    @(posedge clk); #1;
    chk("rst_ready", {31'b0, ready_out}, 32'd1);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single-cycle latency
    issue(4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
    chk("add_latency", {31'b0, valid_out}, 32'd1);
    issue(4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1'b1);
    issue(4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b1);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    issue(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b1);
    issue(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b1);
    issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b1);
    issue(4'd5, 32'd1, 32'h1F, 32'h8000_0000, 1'b0, 1'b1);
    issue(4'd5, 32'd1, 32'h20, 32'd1, 1'b0, 1'b1);
    issue(4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b1);

    // MUL: valid_o exactly 32 cycles after accept, ready_o low throughout
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    bad = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (valid_out || ready_out) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("mul_busy_flags", {31'b0, bad}, 32'd0);
    chk("mul_latency", {31'b0, valid_out}, 32'd1);
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    issue(4'd10, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
    issue(4'd11, 32'h8000_0000, 32'd4, 32'd2, 1'b0, 1'b1);
    issue(4'd10, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b1);
    drain();

    // backpressure with valid_i held during DONE
    ready_in = 1'b0;
    issue(4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1);
    op = 4'd0; src1 = 32'd100; src2 = 32'd100; valid_in = 1'b1;
    held = result;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!valid_out || result !== held || ready_out) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_stable", {31'b0, bad}, 32'd0);
    chk("bp_result", held, 32'd3);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {31'b0, ready_out}, 32'd1);
    chk("bp_release_valid", {31'b0, valid_out}, 32'd0);
    drain();

    // async reset mid-MUL
    issue(4'd10, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_mid_ready", {31'b0, ready_out}, 32'd1);
    chk("rst_mid_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid_out) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_no_pulse", {31'b0, bad}, 32'd0);

    // flush in BUSY
    issue(4'd10, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {31'b0, ready_out}, 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (valid_out) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_pulse", {31'b0, bad}, 32'd0);
    chk("flush_result_held", result, 32'd0);

    // flush with valid_i in IDLE: not accepted
    flush = 1'b1; valid_in = 1'b1; op = 4'd0; src1 = 32'd1; src2 = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    chk("flush_idle_ready", {31'b0, ready_out}, 32'd1);
    chk("flush_idle_valid", {31'b0, valid_out}, 32'd0);

    // illegal ops
    issue(4'd13, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1);
    issue(4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
    issue(4'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b1);
    drain();

    // MUL_EN=0 build: MUL/MULHU are single-cycle illegal
    for (int k = 10; k < 12; k++) begin
      n_op = 4'(k); n_valid_in = 1'b1;
      @(posedge clk); #1;
      n_valid_in = 1'b0;
      chk("nomul_valid", {31'b0, n_valid_out}, 32'd1);
      chk("nomul_illegal", {31'b0, n_illegal}, 32'd1);
      chk("nomul_result", n_result, 32'd0);
      @(posedge clk); #1;
      chk("nomul_ready", {31'b0, n_ready_out}, 32'd1);
    end

    // random legal ops against the reference model
    for (int k = 0; k < 24; k++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = $urandom;
      issue(ro, ra, rb, ref_alu(ro, ra, rb), 1'b0, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
